// File: rtl/quiz_pkg.sv
// Shared types and width helpers for the quiz round controller.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package quiz_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_SHOW,
        S_NEXT,
        S_GAME_OVER
    } state_t;

    // clog2 that never returns less than one bit
    function automatic int clog2_min1(input int v);
        return ($clog2(v) < 1) ? 1 : $clog2(v);
    endfunction

    // choice code 1..NC plus 0 for "none"
    function automatic int choice_w(input int nc);
        return clog2_min1(nc + 1);
    endfunction

    function automatic int qidx_w(input int nq);
        return clog2_min1(nq);
    endfunction

    function automatic int player_w(input int np);
        return clog2_min1(np);
    endfunction

    function automatic int score_w(input int smax);
        return clog2_min1(smax + 1);
    endfunction

endpackage

// File: rtl/joy_press_detect.sv
// Synchronises active-low remote keys and flags a single-key press per player.
// Latency: key sampled low at edge k gives evt high in the cycle after edge k+2.
// Backpressure: none; evt is a one-cycle pulse and is lost if not consumed.
module joy_press_detect
    import quiz_pkg::*;
#(
    parameter int  NP = 2,
    parameter int  NC = 4,
    localparam int CW = choice_w(NC)
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [NP*NC-1:0] joy_n,
    output logic [NP-1:0]    evt,
    output logic [NP*CW-1:0] choice
);

    logic [NP*NC-1:0] sync1;
    logic [NP*NC-1:0] sync2;
    logic [NP*NC-1:0] prev;
    logic [NP-1:0]    evt_d;
    logic [NP*CW-1:0] choice_d;
    logic [CW-1:0]    n_low;
    logic [CW-1:0]    c_sel;

    // two-flop synchroniser plus a delayed copy; released state is all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '1;
            sync2 <= '1;
            prev  <= '1;
        end else begin
            sync1 <= joy_n;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // a press is all-released last cycle and exactly one key low now
    always_comb begin
        evt_d    = '0;
        choice_d = '0;
        n_low    = '0;
        c_sel    = '0;
        for (int p = 0; p < NP; p++) begin
            n_low = '0;
            c_sel = '0;
            for (int c = 0; c < NC; c++) begin
                if (!sync2[p*NC + c]) begin
                    n_low = n_low + 1'b1;
                    c_sel = CW'(c + 1);
                end
            end
            if ((&prev[p*NC +: NC]) && (n_low == CW'(1))) begin
                evt_d[p]              = 1'b1;
                choice_d[p*CW +: CW] = c_sel;
            end
        end
    end

    // register the event so the judge sees a clean, aligned pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            evt    <= '0;
            choice <= '0;
        end else begin
            evt    <= evt_d;
            choice <= choice_d;
        end
    end

endmodule

// File: rtl/quiz_round_ctrl.sv
// Quiz round sequencer: judges first press, keeps scores, lockouts and winner.
// Latency: press to SHOW is four edges from the first sampling edge; SHOW lasts HOLD_CYCLES.
// Backpressure: none; presses outside WAIT, or from locked players, are dropped.
module quiz_round_ctrl
    import quiz_pkg::*;
#(
    parameter int  NUM_PLAYERS   = 2,
    parameter int  NUM_CHOICES   = 4,
    parameter int  NUM_QUESTIONS = 11,
    parameter int  SCORE_MAX     = 5,
    parameter int  HOLD_CYCLES   = 25000000,
    localparam int NP = NUM_PLAYERS,
    localparam int NC = NUM_CHOICES,
    localparam int NQ = NUM_QUESTIONS,
    localparam int CW = choice_w(NC),
    localparam int QW = qidx_w(NQ),
    localparam int PW = player_w(NP),
    localparam int SW = score_w(SCORE_MAX)
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NP*NC-1:0] joy_n,
    input  logic [CW-1:0]    ans_choice,
    output logic [QW-1:0]    q_index,
    output logic [NP*SW-1:0] score,
    output logic [NP-1:0]    lock_mask,
    output logic             result_valid,
    output logic [PW-1:0]    result_player,
    output logic             result_correct,
    output logic             game_over,
    output logic             winner_valid,
    output logic [PW-1:0]    winner
);

    localparam int HW = clog2_min1(HOLD_CYCLES + 1);

    state_t           state;
    state_t           next_state;
    logic [NP-1:0]    evt;
    logic [NP*CW-1:0] choice;
    logic [HW-1:0]    hold_cnt;
    logic             hold_done;
    logic             any_evt;
    logic             take;
    logic [PW-1:0]    sel;
    logic [CW-1:0]    sel_choice;
    logic             sel_correct;
    logic [SW-1:0]    sel_score;
    logic [SW-1:0]    rp_score;
    logic             last_q;
    logic             restart;
    logic [PW-1:0]    best;
    logic [SW-1:0]    best_score;
    logic             tie;

    joy_press_detect #(
        .NP (NP),
        .NC (NC)
    ) u_press (
        .clk    (clk),
        .rst    (rst),
        .joy_n  (joy_n),
        .evt    (evt),
        .choice (choice)
    );

    // lowest-index unlocked player wins a same-cycle race
    always_comb begin
        any_evt    = 1'b0;
        sel        = '0;
        sel_choice = '0;
        for (int p = NP - 1; p >= 0; p--) begin
            if (evt[p] && !lock_mask[p]) begin
                any_evt    = 1'b1;
                sel        = PW'(p);
                sel_choice = choice[p*CW +: CW];
            end
        end
    end

    assign take        = any_evt && (state == S_WAIT);
    assign sel_correct = (sel_choice == ans_choice) && (ans_choice != '0);
    assign sel_score   = score[int'(sel)*SW +: SW];
    assign rp_score    = score[int'(result_player)*SW +: SW];
    assign hold_done   = (hold_cnt == HW'(HOLD_CYCLES - 1));
    assign last_q      = (q_index == QW'(NQ - 1));
    assign restart     = start && ((state == S_IDLE) || (state == S_GAME_OVER));

    // strict maximum search; any equal top score marks a tie
    always_comb begin
        best       = '0;
        best_score = score[0 +: SW];
        tie        = 1'b0;
        for (int p = 1; p < NP; p++) begin
            if (score[p*SW +: SW] > best_score) begin
                best       = PW'(p);
                best_score = score[p*SW +: SW];
                tie        = 1'b0;
            end else if (score[p*SW +: SW] == best_score) begin
                tie = 1'b1;
            end
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // next-state decision
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:      if (start) next_state = S_WAIT;
            S_WAIT:      if (take)  next_state = S_SHOW;
            S_SHOW: begin
                if (hold_done) begin
                    if (result_correct && (rp_score == SW'(SCORE_MAX)))
                        next_state = S_GAME_OVER;
                    else if (result_correct || (&lock_mask))
                        next_state = S_NEXT;
                    else
                        next_state = S_WAIT;
                end
            end
            S_NEXT:      next_state = last_q ? S_GAME_OVER : S_WAIT;
            S_GAME_OVER: if (start) next_state = S_WAIT;
            default:     next_state = S_IDLE;
        endcase
    end

    // state-decoded outputs
    always_comb begin
        result_valid = (state == S_SHOW);
        game_over    = (state == S_GAME_OVER);
    end

    // scores, lockouts, question index, hold timer and registered results
    always_ff @(posedge clk) begin
        if (rst) begin
            q_index        <= '0;
            score          <= '0;
            lock_mask      <= '0;
            result_player  <= '0;
            result_correct <= 1'b0;
            winner_valid   <= 1'b0;
            winner         <= '0;
            hold_cnt       <= '0;
        end else begin
            if (restart) begin
                q_index        <= '0;
                score          <= '0;
                lock_mask      <= '0;
                result_player  <= '0;
                result_correct <= 1'b0;
                winner_valid   <= 1'b0;
                winner         <= '0;
            end
            if (take) begin
                result_player  <= sel;
                result_correct <= sel_correct;
                if (sel_correct) begin
                    if (sel_score < SW'(SCORE_MAX))
                        score[int'(sel)*SW +: SW] <= sel_score + 1'b1;
                end else begin
                    lock_mask[sel] <= 1'b1;
                end
            end
            if (state == S_SHOW)
                hold_cnt <= hold_done ? '0 : hold_cnt + 1'b1;
            if (state == S_NEXT) begin
                lock_mask <= '0;
                if (!last_q)
                    q_index <= q_index + 1'b1;
            end
            // scores are frozen in SHOW/NEXT, so the winner is settled on entry
            if ((next_state == S_GAME_OVER) && (state != S_GAME_OVER)) begin
                winner_valid <= !tie;
                winner       <= tie ? '0 : best;
            end
        end
    end

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// Directed bench for quiz_round_ctrl with NP=2, NC=4, NQ=3, SCORE_MAX=2, HOLD_CYCLES=4.
// Latency: inputs driven and outputs sampled 1ns after each rising edge.
// Backpressure: not applicable; every wait is bounded by a cycle budget.
module tb_quiz_round_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] joy_n = 8'hFF;
    logic [2:0] ans_choice = 3'd0;
    logic [1:0] q_index;
    logic [3:0] score;
    logic [1:0] lock_mask;
    logic       result_valid;
    logic [0:0] result_player;
    logic       result_correct;
    logic       game_over;
    logic       winner_valid;
    logic [0:0] winner;

    int n_tests = 0;
    int n_fail  = 0;
    int lat;
    int slen;

    quiz_round_ctrl #(
        .NUM_PLAYERS   (2),
        .NUM_CHOICES   (4),
        .NUM_QUESTIONS (3),
        .SCORE_MAX     (2),
        .HOLD_CYCLES   (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .joy_n          (joy_n),
        .ans_choice     (ans_choice),
        .q_index        (q_index),
        .score          (score),
        .lock_mask      (lock_mask),
        .result_valid   (result_valid),
        .result_player  (result_player),
        .result_correct (result_correct),
        .game_over      (game_over),
        .winner_valid   (winner_valid),
        .winner         (winner)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [7:0] key(input int p, input int c);
        logic [7:0] m;
        m = 8'hFF;
        m[p*4 + c - 1] = 1'b0;
        return m;
    endfunction

    // pulse keys for one cycle; lat = edges until SHOW, 0 if it never came
    task automatic press_wait(input logic [7:0] keys, input int budget, output int l);
        l = 0;
        joy_n = keys;
        for (int i = 1; i <= budget; i++) begin
            tick(1);
            if (i == 1) joy_n = 8'hFF;
            if (result_valid) begin
                l = i;
                break;
            end
        end
    endtask

    // count SHOW cycles starting from the current (already SHOW) sample
    task automatic show_len(output int n);
        n = 1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (!result_valid) break;
            n++;
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        check("rst_q",      32'(q_index),      32'd0);
        check("rst_score",  32'(score),        32'd0);
        check("rst_lock",   32'(lock_mask),    32'd0);
        check("rst_rvalid", 32'(result_valid), 32'd0);
        check("rst_over",   32'(game_over),    32'd0);
        check("rst_wvalid", 32'(winner_valid), 32'd0);
        rst = 1'b0;
        tick(1);

        // game A
        do_start();
        ans_choice = 3'd2;
        press_wait(key(0, 2), 10, lat);
        check("t1_latency", 32'(lat),            32'd4);
        check("t1_player",  32'(result_player),  32'd0);
        check("t1_correct", 32'(result_correct), 32'd1);
        check("t1_score",   32'(score),          32'h1);
        show_len(slen);
        check("t1_hold",    32'(slen),           32'd4);
        check("t1_next_q",  32'(q_index),        32'd0);
        tick(1);
        check("t1_q1",      32'(q_index),        32'd1);

        ans_choice = 3'd3;
        press_wait(key(1, 1), 10, lat);
        check("t2_latency", 32'(lat),            32'd4);
        check("t2_player",  32'(result_player),  32'd1);
        check("t2_correct", 32'(result_correct), 32'd0);
        check("t2_lock",    32'(lock_mask),      32'd2);
        show_len(slen);
        press_wait(key(1, 1), 10, lat);
        check("t2_locked_ignored", 32'(lat),     32'd0);
        press_wait(key(0, 1), 10, lat);
        check("t2_p0_latency", 32'(lat),         32'd4);
        check("t2_p0_player",  32'(result_player), 32'd0);
        check("t2_lock_all",   32'(lock_mask),   32'd3);
        show_len(slen);
        check("t2_next_lock",  32'(lock_mask),   32'd3);
        tick(1);
        check("t2_lock_clr",   32'(lock_mask),   32'd0);
        check("t2_q2",         32'(q_index),     32'd2);
        check("t2_score",      32'(score),       32'h1);

        ans_choice = 3'd2;
        press_wait(key(0, 2) & key(1, 2), 10, lat);
        check("t3_latency", 32'(lat),            32'd4);
        check("t3_player",  32'(result_player),  32'd0);
        check("t3_score",   32'(score),          32'h2);
        show_len(slen);
        check("t3_over",    32'(game_over),      32'd1);
        check("t3_wvalid",  32'(winner_valid),   32'd1);
        check("t3_winner",  32'(winner),         32'd0);
        check("t3_q",       32'(q_index),        32'd2);

        // game B
        do_start();
        check("t6_restart_score", 32'(score),     32'd0);
        check("t6_restart_q",     32'(q_index),   32'd0);
        check("t6_restart_over",  32'(game_over), 32'd0);
        check("t6_restart_wv",    32'(winner_valid), 32'd0);
        ans_choice = 3'd4;
        press_wait(key(1, 4), 10, lat);
        check("t6_latency", 32'(lat),            32'd4);
        check("t6_player",  32'(result_player),  32'd1);
        check("t6_score",   32'(score),          32'h4);
        joy_n = key(0, 4);
        tick(1);
        joy_n = 8'hFF;
        show_len(slen);
        tick(1);
        check("t6_q1",       32'(q_index),       32'd1);
        check("t6_discard",  32'(score),         32'h4);
        press_wait(8'hFF, 10, lat);
        check("t6_no_queue", 32'(lat),           32'd0);
        ans_choice = 3'd1;
        press_wait(key(1, 1), 10, lat);
        check("t4_latency", 32'(lat),            32'd4);
        check("t4_score",   32'(score),          32'h8);
        show_len(slen);
        check("t4_over",    32'(game_over),      32'd1);
        check("t4_wvalid",  32'(winner_valid),   32'd1);
        check("t4_winner",  32'(winner),         32'd1);
        check("t4_q",       32'(q_index),        32'd1);

        // game C
        do_start();
        ans_choice = 3'd3;
        press_wait(key(0, 3), 10, lat);
        check("t5_q0_lat",  32'(lat),            32'd4);
        show_len(slen);
        tick(1);
        ans_choice = 3'd1;
        press_wait(key(1, 1), 10, lat);
        check("t5_q1_lat",  32'(lat),            32'd4);
        check("t5_score11", 32'(score),          32'h5);
        show_len(slen);
        tick(1);
        check("t5_q2",      32'(q_index),        32'd2);
        press_wait(key(0, 1) & key(0, 2), 10, lat);
        check("t5_multikey", 32'(lat),           32'd0);
        ans_choice = 3'd0;
        press_wait(key(0, 1), 10, lat);
        check("t5_noans_lat",  32'(lat),         32'd4);
        check("t5_noans_corr", 32'(result_correct), 32'd0);
        check("t5_noans_lock", 32'(lock_mask),   32'd1);
        show_len(slen);
        press_wait(key(1, 1), 10, lat);
        check("t5_p1_lat",  32'(lat),            32'd4);
        check("t5_lock_all", 32'(lock_mask),     32'd3);
        show_len(slen);
        check("t5_next_not_over", 32'(game_over), 32'd0);
        tick(1);
        check("t5_over",    32'(game_over),      32'd1);
        check("t5_wvalid",  32'(winner_valid),   32'd0);
        check("t5_winner",  32'(winner),         32'd0);
        check("t5_q_cap",   32'(q_index),        32'd2);
        check("t5_score",   32'(score),          32'h5);

        // game D: reset while in SHOW
        do_start();
        ans_choice = 3'd2;
        press_wait(key(1, 2), 10, lat);
        check("t7_latency", 32'(lat),            32'd4);
        check("t7_score",   32'(score),          32'h4);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("t7_rvalid",  32'(result_valid),   32'd0);
        check("t7_score0",  32'(score),          32'd0);
        check("t7_q0",      32'(q_index),        32'd0);
        check("t7_player",  32'(result_player),  32'd0);
        check("t7_correct", 32'(result_correct), 32'd0);
        press_wait(key(0, 2), 10, lat);
        check("t7_idle_ignores", 32'(lat),       32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
